// File: rtl/alu_muldiv_ctrl.sv
// MIPS ALU control: combinational opcode/funct -> ALUop decode plus a sequential
// multiply/divide unit (shift-add multiply, restoring divide) that owns HI/LO.
module alu_muldiv_ctrl #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             valid,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [3:0]       ALUop,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             md_rd,
    output logic [WIDTH-1:0] md_rdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDIU = 6'h09, OP_SLTI  = 6'h0A,
                           OP_SLTIU = 6'h0B, OP_ANDI  = 6'h0C, OP_ORI   = 6'h0D,
                           OP_XORI  = 6'h0E, OP_LUI   = 6'h0F, OP_LB    = 6'h20,
                           OP_LH    = 6'h21, OP_LWL   = 6'h22, OP_LW    = 6'h23,
                           OP_LBU   = 6'h24, OP_LHU   = 6'h25, OP_LWR   = 6'h26,
                           OP_SB    = 6'h28, OP_SH    = 6'h29, OP_SWL   = 6'h2A,
                           OP_SW    = 6'h2B, OP_SWR   = 6'h2E;

    localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03,
                           FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV  = 6'h07,
                           FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO  = 6'h12,
                           FN_MTLO = 6'h13, FN_MULT = 6'h18, FN_MULTU = 6'h19,
                           FN_DIV  = 6'h1A, FN_DIVU = 6'h1B, FN_ADDU  = 6'h21,
                           FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR    = 6'h25,
                           FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2A,
                           FN_SLTU = 6'h2B;

    localparam logic [3:0] ALU_ADDU = 4'd0, ALU_SUBU = 4'd1, ALU_AND = 4'd2,
                           ALU_OR   = 4'd3, ALU_XOR  = 4'd4, ALU_NOR = 4'd5,
                           ALU_SLT  = 4'd6, ALU_SLTU = 4'd7, ALU_SLL = 4'd8,
                           ALU_SRL  = 4'd9, ALU_SRA  = 4'd10, ALU_LUI = 4'd11,
                           ALU_XXX  = 4'd15;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_STEP - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  acc_hi, acc_lo, opnd;
    logic              neg_q, neg_r, is_div, div_zero;

    logic              md_grp, accept, start_mul, start_div, md_signed;
    logic [WIDTH-1:0]  rs_mag, rt_mag;

    always_comb begin
        ALUop = ALU_XXX;
        if (opcode == OP_RTYPE) begin
            case (funct)
                FN_SLL, FN_SLLV: ALUop = ALU_SLL;
                FN_SRL, FN_SRLV: ALUop = ALU_SRL;
                FN_SRA, FN_SRAV: ALUop = ALU_SRA;
                FN_ADDU:         ALUop = ALU_ADDU;
                FN_SUBU:         ALUop = ALU_SUBU;
                FN_AND:          ALUop = ALU_AND;
                FN_OR:           ALUop = ALU_OR;
                FN_XOR:          ALUop = ALU_XOR;
                FN_NOR:          ALUop = ALU_NOR;
                FN_SLT:          ALUop = ALU_SLT;
                FN_SLTU:         ALUop = ALU_SLTU;
                default:         ALUop = ALU_XXX;
            endcase
        end else begin
            case (opcode)
                OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
                OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR, OP_ADDIU: ALUop = ALU_ADDU;
                OP_SLTI:  ALUop = ALU_SLT;
                OP_SLTIU: ALUop = ALU_SLTU;
                OP_ANDI:  ALUop = ALU_AND;
                OP_ORI:   ALUop = ALU_OR;
                OP_XORI:  ALUop = ALU_XOR;
                OP_LUI:   ALUop = ALU_LUI;
                default:  ALUop = ALU_XXX;
            endcase
        end
    end

    // Handshake: an md instruction is taken on the edge where valid=1 and stall=0;
    // while busy, only md instructions are held back.
    assign md_grp    = (opcode == OP_RTYPE) &&
                       (funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
                                      FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO});
    assign busy      = (state != S_IDLE);
    assign stall     = valid & busy & md_grp;
    assign accept    = valid & ~stall & md_grp;
    assign start_mul = accept && (funct == FN_MULT || funct == FN_MULTU);
    assign start_div = accept && (funct == FN_DIV || funct == FN_DIVU);
    assign md_signed = (funct == FN_MULT) || (funct == FN_DIV);
    assign rs_mag    = (md_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
    assign rt_mag    = (md_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

    assign md_rd     = valid && (opcode == OP_RTYPE) && (funct == FN_MFHI || funct == FN_MFLO);
    assign md_rdata  = (funct == FN_MFHI) ? hi : lo;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_mul)      state_next = S_MUL;
                else if (start_div) state_next = S_DIV;
            end
            S_MUL:   if (cnt == MUL_LAST) state_next = S_FIX;
            S_DIV:   if (cnt == DIV_LAST) state_next = S_FIX;
            S_FIX:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Multiply: acc_lo holds the remaining multiplier bits and fills with product bits from the top.
    logic [WIDTH+MUL_STEP-1:0]   partial, mul_sum;
    logic [2*WIDTH+MUL_STEP-1:0] mul_cat;
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (acc_lo[i]) partial = partial + ({{MUL_STEP{1'b0}}, opnd} << i);
        end
        mul_sum = {{MUL_STEP{1'b0}}, acc_hi} + partial;
        mul_cat = {mul_sum, acc_lo} >> MUL_STEP;
    end

    // Restoring divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
    logic [WIDTH:0] div_shift, div_diff;
    logic           div_ge;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_ge    = (div_shift >= {1'b0, opnd});

    logic [2*WIDTH-1:0] prod, prod_neg;
    assign prod     = {acc_hi, acc_lo};
    assign prod_neg = -prod;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_mul || start_div) begin
                        cnt      <= '0;
                        acc_hi   <= '0;
                        acc_lo   <= start_div ? rs_mag : rt_mag;
                        opnd     <= start_div ? rt_mag : rs_mag;
                        neg_q    <= md_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_r    <= md_signed && rs_val[WIDTH-1];
                        is_div   <= start_div;
                        div_zero <= (rt_val == '0);
                    end
                    if (accept && funct == FN_MTHI) hi <= rs_val;
                    if (accept && funct == FN_MTLO) lo <= rs_val;
                end
                S_MUL: begin
                    {acc_hi, acc_lo} <= mul_cat[2*WIDTH-1:0];
                    cnt              <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    cnt    <= cnt + 1'b1;
                end
                S_FIX: begin
                    if (is_div) begin
                        lo <= div_zero ? '1 : (neg_q ? -acc_lo : acc_lo);
                        hi <= neg_r ? -acc_hi : acc_hi;
                    end else begin
                        {hi, lo} <= neg_q ? prod_neg : prod;
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Directed bench for alu_muldiv_ctrl: ALUop decode table plus hand-built mul/div,
// stall, reset-abort and MTHI/MTLO sequences on a MUL_STEP=1 and a MUL_STEP=4 instance.
module tb_alu_muldiv_ctrl;
    localparam int W = 32;

    localparam logic [3:0] A_ADDU = 4'd0, A_SUBU = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                           A_XOR = 4'd4, A_NOR = 4'd5, A_SLT = 4'd6, A_SLTU = 4'd7,
                           A_SLL = 4'd8, A_SRL = 4'd9, A_SRA = 4'd10, A_LUI = 4'd11,
                           A_XXX = 4'd15;
    localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13,
                           F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B,
                           F_ADDU = 6'h21;

    logic         clk = 1'b0;
    logic         reset, valid;
    logic [5:0]   opcode, funct;
    logic [W-1:0] rs_val, rt_val;
    logic [3:0]   aluop, aluop4;
    logic         stall, busy, done, md_rd, stall4, busy4, done4, md_rd4;
    logic [W-1:0] md_rdata, hi, lo, md_rdata4, hi4, lo4;

    alu_muldiv_ctrl #(.WIDTH(W), .MUL_STEP(1)) u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .valid(valid),
        .rs_val(rs_val), .rt_val(rt_val), .ALUop(aluop), .stall(stall), .busy(busy),
        .done(done), .md_rd(md_rd), .md_rdata(md_rdata), .hi(hi), .lo(lo));

    alu_muldiv_ctrl #(.WIDTH(W), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .valid(valid),
        .rs_val(rs_val), .rt_val(rt_val), .ALUop(aluop4), .stall(stall4), .busy(busy4),
        .done(done4), .md_rd(md_rd4), .md_rdata(md_rdata4), .hi(hi4), .lo(lo4));

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] exp_alu;
    } alu_vec_t;

    localparam int NV = 29;
    alu_vec_t tbl[NV];

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] prev_hi = '0;
    logic [W-1:0] prev_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_md(input logic [5:0] fn, input logic [W-1:0] rs, input logic [W-1:0] rt);
        opcode = 6'h00;
        funct  = fn;
        rs_val = rs;
        rt_val = rt;
        valid  = 1'b1;
        #1;
        check("accept_no_stall", {31'd0, stall}, 32'd0);
        tick;
        valid = 1'b0;
    endtask

    task automatic exec_md(input string name, input logic [5:0] fn, input logic [W-1:0] rs,
                           input logic [W-1:0] rt, input logic [W-1:0] exp_hi,
                           input logic [W-1:0] exp_lo, input int exp_lat4);
        int lat, lat4, busy_cnt;
        start_md(fn, rs, rt);
        lat = 0;
        lat4 = 0;
        busy_cnt = busy ? 1 : 0;
        for (int k = 1; k <= 60 && lat == 0; k++) begin
            tick;
            if (done4 && lat4 == 0) lat4 = k;
            if (done) lat = k;
            else if (busy) busy_cnt++;
            if (k == 10) begin
                check({name, " hi_held"}, hi, prev_hi);
                check({name, " lo_held"}, lo, prev_lo);
            end
        end
        check({name, " latency"}, lat, 33);
        check({name, " busy_cycles"}, busy_cnt, 33);
        check({name, " busy_at_done"}, {31'd0, busy}, 32'd0);
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
        check({name, " step4_latency"}, lat4, exp_lat4);
        check({name, " step4_hi"}, hi4, exp_hi);
        check({name, " step4_lo"}, lo4, exp_lo);
        tick;
        check({name, " done_one_cycle"}, {31'd0, done}, 32'd0);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    initial begin
        int lat, stall_cnt;
        logic done_seen;

        tbl = '{
            '{6'h00, 6'h00, A_SLL},  '{6'h00, 6'h04, A_SLL},  '{6'h00, 6'h02, A_SRL},
            '{6'h00, 6'h06, A_SRL},  '{6'h00, 6'h03, A_SRA},  '{6'h00, 6'h07, A_SRA},
            '{6'h00, 6'h21, A_ADDU}, '{6'h00, 6'h23, A_SUBU}, '{6'h00, 6'h24, A_AND},
            '{6'h00, 6'h25, A_OR},   '{6'h00, 6'h26, A_XOR},  '{6'h00, 6'h27, A_NOR},
            '{6'h00, 6'h2A, A_SLT},  '{6'h00, 6'h2B, A_SLTU}, '{6'h00, 6'h18, A_XXX},
            '{6'h00, 6'h1B, A_XXX},  '{6'h00, 6'h10, A_XXX},  '{6'h00, 6'h08, A_XXX},
            '{6'h23, 6'h18, A_ADDU}, '{6'h2B, 6'h00, A_ADDU}, '{6'h09, 6'h00, A_ADDU},
            '{6'h0A, 6'h00, A_SLT},  '{6'h0B, 6'h00, A_SLTU}, '{6'h0C, 6'h00, A_AND},
            '{6'h0D, 6'h00, A_OR},   '{6'h0E, 6'h00, A_XOR},  '{6'h0F, 6'h00, A_LUI},
            '{6'h04, 6'h00, A_XXX},  '{6'h20, 6'h00, A_ADDU}
        };

        reset  = 1'b1;
        valid  = 1'b0;
        opcode = 6'h09;
        funct  = 6'h00;
        rs_val = '0;
        rt_val = '0;
        tick;
        reset = 1'b0;
        check("reset hi", hi, '0);
        check("reset lo", lo, '0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset step4 busy", {31'd0, busy4}, 32'd0);
        check("addiu aluop", {28'd0, aluop}, {28'd0, A_ADDU});

        for (int i = 0; i < NV; i++) begin
            opcode = tbl[i].op;
            funct  = tbl[i].fn;
            #1;
            check($sformatf("aluop[%0d] op=%02h fn=%02h", i, tbl[i].op, tbl[i].fn),
                  {28'd0, aluop}, {28'd0, tbl[i].exp_alu});
        end

        // Non-md instruction with valid in IDLE must not start anything.
        opcode = 6'h00;
        funct  = F_ADDU;
        valid  = 1'b1;
        tick;
        valid = 1'b0;
        check("addu no busy", {31'd0, busy}, 32'd0);
        check("addu no stall", {31'd0, stall}, 32'd0);

        exec_md("mult_neg",   F_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 9);
        exec_md("multu_max",  F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 9);
        exec_md("mult_minsq", F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 9);
        exec_md("div_neg",    F_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        exec_md("divu_zero",  F_DIVU,  32'd5,        32'd0,        32'd5,         32'hFFFF_FFFF, 33);
        exec_md("div_ovf",    F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
        exec_md("divu_100_7", F_DIVU,  32'd100,      32'd7,        32'd2,         32'd14,        33);

        // MFLO held valid throughout a DIV: stalls every busy cycle, released in the done cycle.
        start_md(F_DIV, 32'd1000, 32'd3);
        valid = 1'b1;
        funct = F_MFLO;
        stall_cnt = 0;
        lat = 0;
        for (int k = 0; k <= 60; k++) begin
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (stall) stall_cnt++;
            if (k == 5) begin
                funct = F_ADDU;
                #1;
                check("addu during div stall", {31'd0, stall}, 32'd0);
                check("addu during div aluop", {28'd0, aluop}, {28'd0, A_ADDU});
                funct = F_MFLO;
            end
            tick;
        end
        check("mflo stall latency", lat, 33);
        check("mflo stall cycles", stall_cnt, 33);
        check("mflo done stall", {31'd0, stall}, 32'd0);
        check("mflo md_rd", {31'd0, md_rd}, 32'd1);
        check("mflo rdata", md_rdata, 32'd333);
        funct = F_MFHI;
        #1;
        check("mfhi rdata", md_rdata, 32'd1);
        tick;
        valid = 1'b0;
        check("mfhi no busy", {31'd0, busy}, 32'd0);
        #1;
        check("md_rd needs valid", {31'd0, md_rd}, 32'd0);

        // Reset in the middle of a DIV aborts it.
        start_md(F_DIVU, 32'd999, 32'd4);
        repeat (9) tick;
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort hi", hi, '0);
        check("abort lo", lo, '0);
        check("abort done", {31'd0, done}, 32'd0);
        done_seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick;
            if (done || busy) done_seen = 1'b1;
        end
        check("abort no done", {31'd0, done_seen}, 32'd0);

        opcode = 6'h00;
        funct  = F_MTHI;
        rs_val = 32'h0000_1234;
        valid  = 1'b1;
        tick;
        check("mthi hi", hi, 32'h0000_1234);
        check("mthi lo", lo, '0);
        check("mthi no done", {31'd0, done}, 32'd0);
        check("mthi no busy", {31'd0, busy}, 32'd0);
        funct  = F_MTLO;
        rs_val = 32'h0000_5678;
        tick;
        valid = 1'b0;
        check("mtlo lo", lo, 32'h0000_5678);
        check("mtlo hi", hi, 32'h0000_1234);
        check("mtlo no done", {31'd0, done}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
